universal_register: RTL
=======================

# universal_register

Parametrised WIDTH-bit register with synchronous, clock-enabled D-latch-style storage and eight operating modes: hold, parallel load, logical shift, rotate, and up/down count. It is the multi-bit, edge-triggered successor of the single-bit gated D latch. It keeps the complementary `Q`/`notQ` output pair and the `En` gating. It sits in the datapath as a general-purpose state element for shift chains, counters and holding registers.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal range 2 to 32.
- `RESET_VALUE`, default 0: value loaded into `Q` on reset; truncated to WIDTH bits.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `En`, input, 1: clock enable; when 0, the register holds regardless of `mode`.
- `mode`, input, 3: operation select (see Operation).
- `D`, input, WIDTH: parallel load data.
- `ser_in_l`, input, 1: serial input entering the MSB on shift-right.
- `ser_in_r`, input, 1: serial input entering the LSB on shift-left.
- `Q`, output, WIDTH: register contents.
- `notQ`, output, WIDTH: bitwise complement of `Q`, always equal to `~Q`.
- `tc`, output, 1: terminal count, combinational from `Q` and `mode`.
- `ser_out_l`, output, 1: equal to `Q[WIDTH-1]`.
- `ser_out_r`, output, 1: equal to `Q[0]`.

## Operation
Priority on each rising `clk` edge: `rst`, then `En`, then `mode`.
- `rst`=1: `Q` takes `RESET_VALUE`. This ignores `En`, `mode` and `D`.
- `rst`=0 and `En`=0: `Q` holds.
- `rst`=0 and `En`=1: `mode` selects the next value of `Q`:
  - 000 HOLD: Q unchanged.
  - 001 LOAD: Q takes D.
  - 010 SHL: Q takes {Q[WIDTH-2:0], ser_in_r}.
  - 011 SHR: Q takes {ser_in_l, Q[WIDTH-1:1]}.
  - 100 ROL: Q takes {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 101 ROR: Q takes {Q[0], Q[WIDTH-1:1]}.
  - 110 UP: Q takes Q+1, modulo 2^WIDTH.
  - 111 DOWN: Q takes Q-1, modulo 2^WIDTH.

`tc` rules:
- In mode 110, `tc` is 1 when Q is all ones.
- In mode 111, `tc` is 1 when Q is zero.
- In every other mode, `tc` is 0.
- `tc` does not depend on `En`. This lets counters be cascaded: drive the next stage's `En` with this stage's `En & tc`.

Arithmetic and boundary rules:
- Arithmetic is unsigned, WIDTH bits, with no saturation. Carry-out and borrow are discarded and appear only through `tc`.
- Wrap-around: in UP, all ones goes to 0; in DOWN, 0 goes to all ones. Both are legal and single-cycle.
- `mode` may change on any cycle. The new mode takes effect at the next edge, and there is no intermediate state.
- No latches are inferred. `Q` is the only stored state; `notQ`, `tc` and the `ser_out_*` outputs are combinational from `Q` and `mode`.

## Timing
- Latency: one clock from sampled inputs to the updated `Q`, `notQ`, `ser_out_l` and `ser_out_r`.
- `tc` follows `mode` combinationally within the same cycle.
- Reset is synchronous. `Q` shows `RESET_VALUE` after the first rising edge with `rst`=1, and the reset value persists for as long as `rst` stays high.
- Before the first reset, `Q` is undefined; the bench must not check it.
- Reset mid-operation: a `rst` pulse during a count or shift sequence aborts it in one cycle. On the first edge after `rst` falls, operation resumes from `RESET_VALUE` using the then-current `mode`.
- Reset values of outputs (with defaults): Q=0, notQ=all ones, ser_out_l=0, ser_out_r=0. `tc` equals 1 if mode is 111, otherwise 0.
- All inputs are sampled only at the rising edge of `clk`; glitches between edges have no effect.

## Test plan
- Reset, load, hold (WIDTH=8): assert `rst` for 1 cycle, giving Q=0x00 and notQ=0xFF. Apply LOAD with D=0xA5 and En=1, giving Q=0xA5 and notQ=0x5A. Then apply En=0 with mode LOAD and D=0x3C for 3 cycles; Q must stay 0xA5.
- Shifts: with Q=0x81, apply SHL with ser_in_r=1, giving Q=0x03. Apply SHR with ser_in_l=0, giving Q=0x01. Apply SHR with ser_in_l=1, giving Q=0x80.
- Rotates: with Q=0x81, apply ROL, giving Q=0x03. Apply ROR twice; Q must be 0x81 after the first ROR and 0xC0 after the second.
- Count wrap: load 0xFE, then apply UP. The sequence must be 0xFF (tc=1) and then 0x00 (tc=0). Switch to DOWN at 0x00: tc=1 immediately, and the next value is 0xFF.
- Cascade: two 4-bit instances, with the high stage's En driven by `En & tc_low` and both in UP mode. From reset, 16 edges must give {hi,lo}=0x10, and 256 edges must wrap to 0x00.
- Mid-operation reset (RESET_VALUE=0x5A): count UP from 0x10 for 5 cycles, then raise `rst` for 1 cycle, giving Q=0x5A. The next UP edge must give 0x5B.

Source files
------------

// File: rtl/universal_register.sv
// WIDTH-bit clock-enabled register: hold, load, shift, rotate and up/down count.
// Q is the only state. notQ, tc and the serial outputs are decoded from Q and mode.
module universal_register #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             tc,
  output logic             ser_out_l,
  output logic             ser_out_r
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = Q;
    case (mode)
      MODE_HOLD: q_next = Q;
      MODE_LOAD: q_next = D;
      MODE_SHL:  q_next = {Q[WIDTH-2:0], ser_in_r};
      MODE_SHR:  q_next = {ser_in_l, Q[WIDTH-1:1]};
      MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
      MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
      MODE_UP:   q_next = Q + ONE;
      MODE_DOWN: q_next = Q - ONE;
      default:   q_next = Q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= RST_Q;
    end else if (En) begin
      Q <= q_next;
    end
  end

  // tc ignores En so stages can be chained with En_next = En & tc.
  always_comb begin
    tc = 1'b0;
    if (mode == MODE_UP) begin
      tc = &Q;
    end else if (mode == MODE_DOWN) begin
      tc = ~|Q;
    end
  end

  assign notQ      = ~Q;
  assign ser_out_l = Q[WIDTH-1];
  assign ser_out_r = Q[0];

endmodule
